pipe_issue_ctrl: RTL

PIPE_ISSUE_CTRL -- requirements
Module: pipe_issue_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 56 +++++
 rtl/pipe_cmd_fifo.sv | 67 ++++++
 rtl/pipe_issue_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the issue controller: command layout, ALU function
// codes, legality limit and operand-use decode.
package pipe_ctrl_pkg;

  localparam int CMD_W = 24;

  // ALU function codes understood by the datapath; 12..15 are unassigned.
  typedef enum logic [3:0] {
    FN_ADD  = 4'd0,
    FN_SUB  = 4'd1,
    FN_AND  = 4'd2,
    FN_NEGA = 4'd3,
    FN_MOVB = 4'd4,
    FN_OR   = 4'd5,
    FN_XOR  = 4'd6,
    FN_SLT  = 4'd7,
    FN_SHLA = 4'd8,
    FN_NOTB = 4'd9,
    FN_LD   = 4'd10,
    FN_ST   = 4'd11
  } func_e;

  localparam logic [3:0] FUNC_LEGAL_MAX = 4'd11;

  // One queued command; field order fixes the 24-bit FIFO entry layout.
  typedef struct packed {
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [3:0] func;
    logic [7:0] addr;
  } cmd_t;

  function automatic logic func_legal(input logic [3:0] f);
    return (f <= FUNC_LEGAL_MAX);
  endfunction

  // rs1 is read by the two-operand ops and the rs1-only ops.
  function automatic logic uses_rs1(input logic [3:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT,
      FN_NEGA, FN_SHLA, FN_LD, FN_ST: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // rs2 is read by the two-operand ops and the rs2-only ops.
  function automatic logic uses_rs2(input logic [3:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT,
      FN_MOVB, FN_NOTB: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_cmd_fifo.sv
// Command FIFO: DEPTH entries of one packed command, registered occupancy.
// ready_o depends only on the stored occupancy, so a full FIFO never accepts
// a command in the same cycle it pops one.
module pipe_cmd_fifo
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [CMD_W-1:0] wdata_i,
  output logic             ready_o,
  input  logic             pop_i,
  output logic [CMD_W-1:0] rdata_o,
  output logic             valid_o
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign ready_o = (count_q < FULL_CNT);
  assign valid_o = (count_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && ready_o;
  assign pop_ok  = pop_i && valid_o;

  // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and occupancy, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are qualified by occupancy so need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller: queues commands, drops illegal function codes,
// holds the head on a read-after-write hazard against a WB_LAT-deep
// in-flight scoreboard and issues at most one command per cycle.
module pipe_issue_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WB_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_func,
  input  logic [7:0]  in_addr,
  output logic        iss_valid,
  output logic [3:0]  iss_rs1,
  output logic [3:0]  iss_rs2,
  output logic [3:0]  iss_rd,
  output logic [3:0]  iss_func,
  output logic [7:0]  iss_addr,
  output logic        stall,
  output logic [7:0]  drop_cnt,
  output logic [15:0] iss_cnt
);

  cmd_t             in_cmd;
  cmd_t             head;
  logic [CMD_W-1:0] head_raw;
  logic             head_vld;
  logic             fifo_ready;

  logic             sb_vld_q [WB_LAT];
  logic [3:0]       sb_rd_q  [WB_LAT];

  logic             head_legal, hazard;
  logic             do_issue, do_drop, do_pop, do_hold;

  cmd_t             iss_q, iss_d;
  logic             iss_valid_q, iss_valid_d;
  logic             stall_q, stall_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [15:0]      iss_cnt_q, iss_cnt_d;

  assign in_cmd = {in_rs1, in_rs2, in_rd, in_func, in_addr};

  pipe_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .wdata_i (in_cmd),
    .ready_o (fifo_ready),
    .pop_i   (do_pop),
    .rdata_o (head_raw),
    .valid_o (head_vld)
  );

  assign in_ready = fifo_ready;
  assign head     = cmd_t'(head_raw);

  // RAW check of the head's used source registers against in-flight rds.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WB_LAT; i++) begin
      if (sb_vld_q[i] &&
          ((uses_rs1(head.func) && (sb_rd_q[i] == head.rs1)) ||
           (uses_rs2(head.func) && (sb_rd_q[i] == head.rs2))))
        hazard = 1'b1;
    end
  end

  // Head disposition: issue, drop, or hold; an empty FIFO does nothing.
  always_comb begin
    head_legal = func_legal(head.func);
    do_issue   = head_vld && head_legal && !hazard;
    do_drop    = head_vld && !head_legal;
    do_hold    = head_vld && head_legal && hazard;
    do_pop     = do_issue || do_drop;
  end

  // Next-state for issue outputs and counters.
  always_comb begin
    iss_valid_d = do_issue;
    stall_d     = do_hold;
    iss_d       = do_issue ? head : iss_q;
    iss_cnt_d   = do_issue ? iss_cnt_q + 16'd1 : iss_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (do_drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Issue stage boundary: registered command, pulse, stall and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid_q <= 1'b0;
      stall_q     <= 1'b0;
      iss_q       <= '0;
      drop_cnt_q  <= '0;
      iss_cnt_q   <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      stall_q     <= stall_d;
      iss_q       <= iss_d;
      drop_cnt_q  <= drop_cnt_d;
      iss_cnt_q   <= iss_cnt_d;
    end
  end

  // Scoreboard valid bits shift every cycle; slot 0 marks a fresh issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WB_LAT; i++) sb_vld_q[i] <= 1'b0;
    end else begin
      sb_vld_q[0] <= do_issue;
      for (int i = 1; i < WB_LAT; i++) sb_vld_q[i] <= sb_vld_q[i-1];
    end
  end

  // Scoreboard rd tags travel alongside the valid bits; qualified by them.
  always_ff @(posedge clk) begin
    sb_rd_q[0] <= head.rd;
    for (int i = 1; i < WB_LAT; i++) sb_rd_q[i] <= sb_rd_q[i-1];
  end

  assign iss_valid = iss_valid_q;
  assign iss_rs1   = iss_q.rs1;
  assign iss_rs2   = iss_q.rs2;
  assign iss_rd    = iss_q.rd;
  assign iss_func  = iss_q.func;
  assign iss_addr  = iss_q.addr;
  assign stall     = stall_q;
  assign drop_cnt  = drop_cnt_q;
  assign iss_cnt   = iss_cnt_q;

endmodule
